// File: rtl/ebi_bridge_mc_if.sv
// Purpose: bundles the EBI host bus, command FIFO and sample FIFO signals
//          seen by ebi_bridge_mc into one connection.
// Ports:   slave modport = bridge side; master modport = host/FIFO side.
interface ebi_bridge_mc_if #(
  parameter int DW        = 16,
  parameter int AW        = 19,
  parameter int CMD_WORDS = 5,
  parameter int NCH       = 2
) ();
  // EBI host bus
  logic [DW-1:0]           data_in;
  logic [DW-1:0]           data_out;
  logic [AW-1:0]           addr;
  logic                    rd;
  logic                    wr;
  logic                    cs;
  // command FIFO write side
  logic [CMD_WORDS*DW-1:0] cmd_fifo_data_in;
  logic                    cmd_fifo_wr_en;
  logic                    cmd_fifo_full;
  logic                    cmd_fifo_almost_full;
  logic                    cmd_fifo_empty;
  // sample FIFO read side, one FIFO per channel
  logic [NCH*DW-1:0]       sample_fifo_data_out;
  logic [NCH-1:0]          sample_fifo_rd_en;
  logic [NCH-1:0]          sample_fifo_empty;
  // level interrupt
  logic                    irq;

  modport slave (
    input  data_in, addr, rd, wr, cs,
    input  cmd_fifo_full, cmd_fifo_almost_full, cmd_fifo_empty,
    input  sample_fifo_data_out, sample_fifo_empty,
    output data_out, cmd_fifo_data_in, cmd_fifo_wr_en, sample_fifo_rd_en, irq
  );

  modport master (
    output data_in, addr, rd, wr, cs,
    output cmd_fifo_full, cmd_fifo_almost_full, cmd_fifo_empty,
    output sample_fifo_data_out, sample_fifo_empty,
    input  data_out, cmd_fifo_data_in, cmd_fifo_wr_en, sample_fifo_rd_en, irq
  );
endinterface

// File: rtl/ebi_bridge_mc.sv
// Purpose: EBI slave that assembles CMD_WORDS written words into one command
//          FIFO entry and serves NCH prefetched sample channels plus STATUS/IRQ_MASK.
// Latency: bus inputs registered once; data_out valid 1 cycle after the
//          registered read strobe; irq 1 cycle after its status source.
// Backpressure: a command offered while the command FIFO is full is dropped
//          and flagged (CMD_OVF); reading an unprimed channel flags SMP_UNF.
// Ports:   clk, rst (async, active-high); bus = ebi_bridge_mc_if.slave.
module ebi_bridge_mc #(
  parameter int DW        = 16,
  parameter int AW        = 19,
  parameter int CMD_WORDS = 5,
  parameter int NCH       = 2
) (
  input  logic            clk,
  input  logic            rst,
  ebi_bridge_mc_if.slave  bus
);

  localparam int SMP_BASE  = CMD_WORDS + 1;
  localparam int MASK_ADDR = CMD_WORDS + NCH + 1;

  typedef enum logic [2:0] {IDLE, FETCH, CMD_PUSH, WAIT_RELEASE, RD_HOLD} state_t;
  typedef enum logic [1:0] {CH_EMPTY, CH_POP, CH_FULL} ch_state_t;

  // registered bus strobes
  logic [AW-1:0] addr_d;
  logic [DW-1:0] data_in_d;
  logic          rd_d, wr_d, rd_dd, wr_dd;

  state_t        state;
  logic [DW-1:0] words [CMD_WORDS];
  logic [DW-1:0] irq_mask;
  logic          cmd_ovf, smp_unf;
  logic [NCH-1:0] rd_sel;     // one-hot channel of the read being held
  logic           rd_ok;      // channel was primed when that read began
  logic           stat_rd;    // a STATUS read is in progress

  ch_state_t     ch_state [NCH];
  logic [DW-1:0] cap [NCH];
  logic [NCH-1:0] valid, smp_sel, consume, rd_en;

  logic [DW-1:0] status, rdata;
  logic          rd_fall, wr_start, clr_sticky, set_ovf, set_unf;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_d    <= '0;
      data_in_d <= '0;
      rd_d      <= 1'b0;
      wr_d      <= 1'b0;
      rd_dd     <= 1'b0;
      wr_dd     <= 1'b0;
    end else begin
      addr_d    <= bus.addr;
      data_in_d <= bus.data_in;
      rd_d      <= bus.rd & bus.cs;
      wr_d      <= bus.wr & bus.cs;
      rd_dd     <= rd_d;
      wr_dd     <= wr_d;
    end
  end

  assign rd_fall  = rd_dd & ~rd_d;
  // a write is acted on once, on its first registered cycle
  assign wr_start = wr_d & ~wr_dd;

  always_comb begin
    valid   = '0;
    smp_sel = '0;
    for (int c = 0; c < NCH; c++) begin
      valid[c]   = (ch_state[c] == CH_FULL);
      smp_sel[c] = (addr_d == AW'(SMP_BASE + c));
    end
  end

  always_comb begin
    status    = '0;
    status[0] = bus.cmd_fifo_full;
    status[1] = bus.cmd_fifo_almost_full;
    status[2] = bus.cmd_fifo_empty;
    status[3] = cmd_ovf;
    status[4] = smp_unf;
    for (int c = 0; c < NCH; c++) status[8+c] = valid[c];
  end

  // write-only and unmapped addresses read back as zero
  always_comb begin
    rdata = '0;
    if (addr_d == AW'(0))         rdata = status;
    if (addr_d == AW'(MASK_ADDR)) rdata = irq_mask;
    for (int c = 0; c < NCH; c++)
      if (smp_sel[c]) rdata = cap[c];
  end

  // a newly raised flag beats a simultaneous STATUS-read clear
  assign clr_sticky = rd_fall & stat_rd;
  assign set_ovf    = (state == CMD_PUSH) & bus.cmd_fifo_full;
  assign set_unf    = (state == RD_HOLD) & rd_fall & ~rd_ok;
  assign consume    = (state == RD_HOLD && rd_fall && rd_ok) ? rd_sel : '0;

  assign bus.cmd_fifo_wr_en = (state == CMD_PUSH) & ~bus.cmd_fifo_full;

  // word 1 lands in the most significant slot
  for (genvar k = 0; k < CMD_WORDS; k++) begin : g_cmd
    assign bus.cmd_fifo_data_in[(CMD_WORDS-1-k)*DW +: DW] = words[k];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      for (int k = 0; k < CMD_WORDS; k++) words[k] <= '0;
      irq_mask     <= '0;
      cmd_ovf      <= 1'b0;
      smp_unf      <= 1'b0;
      rd_sel       <= '0;
      rd_ok        <= 1'b0;
      stat_rd      <= 1'b0;
      bus.data_out <= '0;
      bus.irq      <= 1'b0;
    end else begin
      if (rd_d) bus.data_out <= rdata;
      bus.irq <= |(status & irq_mask);
      cmd_ovf <= (cmd_ovf & ~clr_sticky) | set_ovf;
      smp_unf <= (smp_unf & ~clr_sticky) | set_unf;
      if (rd_d && addr_d == AW'(0)) stat_rd <= 1'b1;
      else if (rd_fall)             stat_rd <= 1'b0;

      case (state)
        IDLE: state <= FETCH;
        FETCH: begin
          if (wr_start) begin
            for (int k = 0; k < CMD_WORDS; k++)
              if (addr_d == AW'(k + 1)) words[k] <= data_in_d;
            if (addr_d == AW'(MASK_ADDR)) irq_mask <= data_in_d;
            if (addr_d == AW'(CMD_WORDS)) state <= CMD_PUSH;
          end else if (rd_d && |smp_sel) begin
            rd_sel <= smp_sel;
            rd_ok  <= |(smp_sel & valid);
            state  <= RD_HOLD;
          end
        end
        CMD_PUSH:     state <= WAIT_RELEASE;
        WAIT_RELEASE: if (!rd_d && !wr_d) state <= FETCH;
        RD_HOLD:      if (rd_fall) state <= FETCH;
        default:      state <= IDLE;
      endcase
    end
  end

  // Per-channel prefetch. rd_en is decoded from EMPTY so the 1-cycle FIFO
  // read data is present during POP, where it is captured.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < NCH; c++) begin
        ch_state[c] <= CH_EMPTY;
        cap[c]      <= '0;
      end
    end else begin
      for (int c = 0; c < NCH; c++) begin
        case (ch_state[c])
          CH_EMPTY: if (!bus.sample_fifo_empty[c]) ch_state[c] <= CH_POP;
          CH_POP: begin
            cap[c]      <= bus.sample_fifo_data_out[c*DW +: DW];
            ch_state[c] <= CH_FULL;
          end
          CH_FULL: if (consume[c]) ch_state[c] <= CH_EMPTY;
          default: ch_state[c] <= CH_EMPTY;
        endcase
      end
    end
  end

  always_comb begin
    rd_en = '0;
    for (int c = 0; c < NCH; c++)
      rd_en[c] = ~rst & (ch_state[c] == CH_EMPTY) & ~bus.sample_fifo_empty[c];
  end
  assign bus.sample_fifo_rd_en = rd_en;

endmodule

// File: tb/tb_ebi_bridge_mc.sv
// Purpose: directed self-checking bench for ebi_bridge_mc with a command-push
//          scoreboard, a read-data scoreboard and a 1-cycle-latency sample FIFO model.
// Ports:   none (top level); drives the bridge through ebi_bridge_mc_if.
module tb_ebi_bridge_mc;
  localparam int DW = 16, AW = 19, CW = 5, NCH = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ebi_bridge_mc_if #(.DW(DW), .AW(AW), .CMD_WORDS(CW), .NCH(NCH)) bus ();
  ebi_bridge_mc #(.DW(DW), .AW(AW), .CMD_WORDS(CW), .NCH(NCH)) dut (
    .clk(clk), .rst(rst), .bus(bus));

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // sample FIFO model: read data appears one cycle after rd_en
  logic [15:0] sf_mem [NCH][16];
  int          sf_wp [NCH] = '{0, 0};
  int          sf_rp [NCH] = '{0, 0};
  int          rd_cnt [NCH] = '{0, 0};
  int          rd_empty_err = 0;
  logic [NCH-1:0]    sf_empty;
  logic [NCH*DW-1:0] sf_dout = '0;

  always_comb begin
    sf_empty = '0;
    for (int c = 0; c < NCH; c++) sf_empty[c] = (sf_wp[c] == sf_rp[c]);
  end
  assign bus.sample_fifo_empty    = sf_empty;
  assign bus.sample_fifo_data_out = sf_dout;

  always @(posedge clk) begin
    for (int c = 0; c < NCH; c++) begin
      if (bus.sample_fifo_rd_en[c]) begin
        rd_cnt[c] <= rd_cnt[c] + 1;
        if (sf_empty[c]) rd_empty_err <= rd_empty_err + 1;
        else begin
          sf_dout[c*DW +: DW] <= sf_mem[c][sf_rp[c] % 16];
          sf_rp[c] <= sf_rp[c] + 1;
        end
      end
    end
  end

  task automatic sf_push(input int c, input logic [15:0] v);
    sf_mem[c][sf_wp[c] % 16] = v;
    sf_wp[c] = sf_wp[c] + 1;
  endtask

  // command scoreboard
  logic [79:0] cmd_q [$];
  int push_cnt = 0;
  int unexpected = 0;
  always @(negedge clk) begin
    if (bus.cmd_fifo_wr_en) begin
      push_cnt++;
      if (cmd_q.size() > 0) chk("push_data", bus.cmd_fifo_data_in, cmd_q.pop_front());
      else unexpected++;
    end
  end

  // read-data scoreboard
  logic [15:0] rd_q [$];

  task automatic ebi_write(input int a, input logic [15:0] d);
    @(posedge clk); #1;
    bus.addr = AW'(a); bus.data_in = d; bus.wr = 1'b1; bus.cs = 1'b1;
    repeat (3) @(posedge clk); #1;
    bus.wr = 1'b0; bus.cs = 1'b0;
    repeat (5) @(posedge clk);
  endtask

  task automatic ebi_read(input string tag, input int a, input logic [15:0] exp);
    logic [15:0] e;
    @(posedge clk); #1;
    bus.addr = AW'(a); bus.rd = 1'b1; bus.cs = 1'b1;
    rd_q.push_back(exp);
    repeat (3) @(posedge clk);
    @(negedge clk);
    e = rd_q.pop_front();
    chk(tag, 80'(bus.data_out), 80'(e));
    @(posedge clk); #1;
    bus.rd = 1'b0; bus.cs = 1'b0;
    repeat (5) @(posedge clk);
  endtask

  task automatic write_cmd(input logic [79:0] v);
    cmd_q.push_back(v);
    for (int k = 0; k < CW; k++) ebi_write(k + 1, v[(CW-1-k)*16 +: 16]);
  endtask

  initial begin
    int t_rd, t_irq;
    bit found;
    bus.addr = '0; bus.data_in = '0; bus.rd = 1'b0; bus.wr = 1'b0; bus.cs = 1'b0;
    bus.cmd_fifo_full = 1'b0; bus.cmd_fifo_almost_full = 1'b0; bus.cmd_fifo_empty = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_data_out", 80'(bus.data_out), 80'h0);
    chk("rst_irq", 80'(bus.irq), 80'h0);
    chk("rst_wr_en", 80'(bus.cmd_fifo_wr_en), 80'h0);
    chk("rst_rd_en", 80'(bus.sample_fifo_rd_en), 80'h0);
    chk("rst_cmd_data", bus.cmd_fifo_data_in, 80'h0);
    rst = 1'b0;

    // full command, FIFO has room
    write_cmd(80'h11112222333344445555);
    chk("push_cnt_1", 80'(push_cnt), 80'd1);
    chk("cmd_hold", bus.cmd_fifo_data_in, 80'h11112222333344445555);

    // command FIFO full: dropped, overflow flag visible once
    bus.cmd_fifo_full = 1'b1; bus.cmd_fifo_almost_full = 1'b1; bus.cmd_fifo_empty = 1'b0;
    for (int k = 0; k < CW; k++) ebi_write(k + 1, 16'h1111 * 16'(k + 1));
    chk("push_cnt_full", 80'(push_cnt), 80'd1);
    ebi_read("status_ovf", 0, 16'h000B);
    ebi_read("status_ovf_clr", 0, 16'h0003);
    bus.cmd_fifo_full = 1'b0; bus.cmd_fifo_almost_full = 1'b0; bus.cmd_fifo_empty = 1'b1;

    // underflow read of channel 0
    ebi_read("smp0_stale", 6, 16'h0000);
    ebi_read("status_unf", 0, 16'h0014);
    ebi_read("status_unf_clr", 0, 16'h0004);
    chk("rd_cnt0_unf", 80'(rd_cnt[0]), 80'd0);

    // channel 1 prefetch and refill
    @(posedge clk); #1;
    sf_push(1, 16'hA001); sf_push(1, 16'hA002);
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("rd_cnt1_pref", 80'(rd_cnt[1]), 80'd1);
    ebi_read("status_valid1", 0, 16'h0204);
    ebi_read("smp1_a", 7, 16'hA001);
    chk("rd_cnt1_refill", 80'(rd_cnt[1]), 80'd2);
    ebi_read("smp1_b", 7, 16'hA002);
    chk("rd_cnt1_final", 80'(rd_cnt[1]), 80'd2);
    ebi_read("status_drained", 0, 16'h0004);

    // interrupt on channel 0 valid
    ebi_write(8, 16'h0100);
    ebi_read("mask_rb", 8, 16'h0100);
    chk("irq_idle", 80'(bus.irq), 80'h0);
    @(posedge clk); #1;
    sf_push(0, 16'hB001);
    t_rd = -100; t_irq = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.sample_fifo_rd_en[0]) t_rd = i;
      if (bus.irq) begin t_irq = i; break; end
    end
    chk("irq_rise_lat", 80'(t_irq - t_rd), 80'd3);
    chk("irq_high", 80'(bus.irq), 80'h1);
    ebi_read("smp0_b", 6, 16'hB001);
    chk("irq_fall", 80'(bus.irq), 80'h0);
    chk("rd_cnt0", 80'(rd_cnt[0]), 80'd1);

    // reset mid-command and mid-POP
    ebi_write(1, 16'hC001); ebi_write(2, 16'hC002); ebi_write(3, 16'hC003);
    @(posedge clk); #1;
    sf_push(1, 16'hD001);
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.sample_fifo_rd_en[1]) begin found = 1'b1; break; end
    end
    chk("pop_seen", 80'(found), 80'h1);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("arst_data_out", 80'(bus.data_out), 80'h0);
    chk("arst_irq", 80'(bus.irq), 80'h0);
    chk("arst_cmd_data", bus.cmd_fifo_data_in, 80'h0);
    chk("arst_wr_en", 80'(bus.cmd_fifo_wr_en), 80'h0);
    sf_push(1, 16'hD002);
    #1;
    chk("arst_rd_en", 80'(bus.sample_fifo_rd_en), 80'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("no_push_after_rst", 80'(push_cnt), 80'd1);
    chk("rd_cnt1_reprefetch", 80'(rd_cnt[1]), 80'd4);
    ebi_read("smp1_after_rst", 7, 16'hD002);
    ebi_read("status_after_rst", 0, 16'h0004);

    write_cmd(80'h123456789ABCDEF00F0F);
    chk("push_cnt_2", 80'(push_cnt), 80'd2);
    chk("unexpected_push", 80'(unexpected), 80'd0);
    chk("rd_en_on_empty", 80'(rd_empty_err), 80'd0);
    chk("cmd_q_drained", 80'(cmd_q.size()), 80'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end
endmodule
